// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and constants for the parametrised register file.
// Default widths match the CPU top; port_lsb() locates a port inside a packed bus.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_e;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;

  // LSB position of port idx within a bus packed as width-bit fields.
  function automatic int port_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// regfile_clear_seq: post-reset clear sequencer for regfile_param.
// Walks every entry once to zero it. While the walk runs, busy is high and
// writes are refused; a refused write raises wr_drop on the following cycle.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   CLEAR | zeroing entry[clr_cnt] each edge; busy high, writes dropped
//   READY | normal operation; writes accepted
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  output logic              busy,
  output logic              wr_drop,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

  rf_state_e         state;
  rf_state_e         state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] clr_cnt_nxt;

  // State, counter and drop-flag registers; reset restarts the clear from 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      wr_drop <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
      wr_drop <= wr_en & busy;
    end
  end

  // Next-state: advance through every entry, leave CLEAR as the counter wraps.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    if (state == CLEAR) begin
      clr_cnt_nxt = clr_cnt + CNT_ONE;
      if (clr_cnt == CNT_LAST) begin
        state_nxt = READY;
      end
    end
  end

  // Outputs; the array is left alone on a reset edge.
  always_comb begin
    busy     = (state == CLEAR);
    clr_we   = (state == CLEAR) && !rst;
    clr_addr = clr_cnt;
  end

endmodule

// File: rtl/regfile_param.sv
// regfile_param: parametrised multi-read, single-write register file.
// Entries are zeroed by a clear sequence after reset; optional hardwired-zero
// entry 0. Define REGFILE_BYPASS_EN to forward the write data to matching
// read ports in the same cycle.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     busy,
  output logic                     wr_drop
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_zero;
  logic              wr_ok;
  logic [ADDR_W-1:0] ra;
  logic [DATA_W-1:0] rv;

  regfile_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .busy     (busy),
    .wr_drop  (wr_drop),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Qualify the write port: no writes during reset, clear, or to a hardwired zero.
  always_comb begin
    wr_zero = (ZERO_REG != 0) && (wr_addr == '0);
    wr_ok   = wr_en && !rst && !busy && !wr_zero;
  end

  // Array update: the clear sequencer owns the array while busy.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Combinational read muxes, one per port; zero while busy or for a hardwired r0.
  always_comb begin
    rd_data = '0;
    ra      = '0;
    rv      = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra = rd_addr[port_lsb(i, ADDR_W) +: ADDR_W];
      rv = mem[ra];
      if (busy || ((ZERO_REG != 0) && (ra == '0))) begin
        rv = '0;
      end
`ifdef REGFILE_BYPASS_EN
      else if (wr_en && (ra == wr_addr)) begin
        rv = wr_data;
      end
`endif
      rd_data[port_lsb(i, DATA_W) +: DATA_W] = rv;
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: directed vectors for regfile_param with default geometry,
// plus a ZERO_REG=1 instance sharing the same stimulus.
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  logic [31:0] rd_data_z;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        busy, busy_z;
  logic        wr_drop, wr_drop_z;

  int vec_cnt  = 0;
  int miscmp   = 0;
  int busy_len = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always #5 clk = ~clk;

  regfile_param dut (
    .clk     (clk),
    .rst     (rst),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .wr_drop (wr_drop)
  );

  regfile_param #(.ZERO_REG(1)) dut_z (
    .clk     (clk),
    .rst     (rst),
    .rd_addr (rd_addr),
    .rd_data (rd_data_z),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy_z),
    .wr_drop (wr_drop_z)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count busy cycles after rst falls; optionally pulse a write or a reset mid-clear.
  task automatic run_clear(input int wr_cyc, input int rst_cyc, output int n);
    n = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (!busy) break;
      if (cyc == 1) chk("rd_zero_busy", rd_data, 32'h0);
      if (cyc == wr_cyc) begin
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h1234;
      end
      if (cyc == rst_cyc) rst = 1'b1;
      tick();
      n++;
      if (cyc == wr_cyc) begin
        chk("wr_drop_pulse", {31'b0, wr_drop}, 32'h1);
        wr_en = 1'b0;
      end else if (cyc == wr_cyc + 1) begin
        chk("wr_drop_clear", {31'b0, wr_drop}, 32'h0);
      end
      if (cyc == rst_cyc) begin
        chk("wr_drop_rst", {31'b0, wr_drop}, 32'h0);
        rst = 1'b0;
        n = 0;
      end
    end
  endtask

  initial begin
    rst = 1'b1; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    tick();
    tick();
    chk("busy_reset", {31'b0, busy}, 32'h1);
    chk("wr_drop_reset", {31'b0, wr_drop}, 32'h0);
    rst = 1'b0;
    run_clear(4, 0, busy_len);
    chk("busy_len", busy_len, 32'd16);
    chk("busy_done", {31'b0, busy}, 32'h0);

    for (int a = 0; a < 16; a++) begin
      rd_addr = {a[3:0], a[3:0]};
      #1;
      chk("clear_rd", rd_data, 32'h0);
    end

    // Write 0xBEEF to r5.
    rd_addr = {4'd5, 4'd5}; wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF;
    #1;
    chk("r5_same_cyc", rd_data, BYP ? 32'hBEEF_BEEF : 32'h0);
    tick();
    wr_en = 1'b0;
    #1;
    chk("r5_next_cyc", rd_data, 32'hBEEF_BEEF);
    rd_addr = {4'd6, 4'd6};
    #1;
    chk("r6_untouched", rd_data, 32'h0);
    rd_addr = {4'd3, 4'd3};
    #1;
    chk("r3_dropped", rd_data, 32'h0);

    // Write 0x00A5 to r7 with port0 on r7, port1 on r5.
    rd_addr = {4'd5, 4'd7}; wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h00A5;
    #1;
    chk("r7_same_cyc", rd_data, BYP ? 32'hBEEF_00A5 : 32'hBEEF_0000);
    tick();
    wr_en = 1'b0;
    #1;
    chk("r7_next_cyc", rd_data, 32'hBEEF_00A5);
    chk("wr_drop_ready", {31'b0, wr_drop}, 32'h0);

    // Write 0xFFFF to r0 on both instances.
    rd_addr = {4'd0, 4'd0}; wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF;
    #1;
    chk("r0z_same_cyc", rd_data_z, 32'h0);
    chk("r0_same_cyc", rd_data, BYP ? 32'hFFFF_FFFF : 32'h0);
    tick();
    wr_en = 1'b0;
    #1;
    chk("r0z_next_cyc", rd_data_z, 32'h0);
    chk("wr_drop_z", {31'b0, wr_drop_z}, 32'h0);
    chk("r0_next_cyc", rd_data, 32'hFFFF_FFFF);
    rd_addr = {4'd7, 4'd5};
    #1;
    chk("z_r5_r7", rd_data_z, 32'h00A5_BEEF);

    // r15 = 0x5555, then reset with a second reset at clear cycle 10.
    wr_en = 1'b1; wr_addr = 4'd15; wr_data = 16'h5555;
    tick();
    wr_en = 1'b0;
    rd_addr = {4'd15, 4'd15};
    #1;
    chk("r15_written", rd_data, 32'h5555_5555);
    rst = 1'b1;
    tick();
    chk("busy_rst2", {31'b0, busy}, 32'h1);
    rst = 1'b0;
    run_clear(0, 10, busy_len);
    chk("busy_len_restart", busy_len, 32'd16);
    chk("busy_done2", {31'b0, busy}, 32'h0);
    #1;
    chk("r15_cleared", rd_data, 32'h0);
    rd_addr = {4'd7, 4'd5};
    #1;
    chk("r5_r7_cleared", rd_data, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the CPU's 16x16 two-read/one-write register file.
- Generalised in data width, depth and read-port count.
- Adds a synchronous self-clearing sequencer (busy flag), optional hardwired-zero register 0, and write-conflict flagging.
- Sits between decode (read addresses) and writeback (write port) in the datapath.

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2, number of independent combinational read ports (1..4).
- ZERO_REG, 0, 1 = entry 0 always reads 0 and ignores writes.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i = bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data, same packing.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- busy  out  1  clear sequence in progress; writes dropped.
- wr_drop  out  1  registered pulse: a write was attempted while busy.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- FSM states: CLEAR, READY.
- rst high at a clock edge:
  - state <= CLEAR, clr_cnt <= 0, busy = 1, wr_drop <= 0.
  - Array contents are not touched on that edge.
- CLEAR with rst low, each edge:
  - entry[clr_cnt] <= 0; clr_cnt increments.
  - When clr_cnt == DEPTH-1 is written, state <= READY.
  - busy therefore stays high for exactly DEPTH cycles after rst falls.
- busy = (state == CLEAR); combinational from state.
- READY: on a clock edge with wr_en = 1, entry[wr_addr] <= wr_data.
  - Visible on rd_data from the following cycle (without bypass).
- Write while busy:
  - The write is ignored.
  - wr_drop = 1 for one cycle on the following edge; otherwise wr_drop <= 0 each cycle.
- Reads:
  - Combinational: rd_data[i] = entry[rd_addr[i]].
  - While busy, all rd_data read 0 regardless of array contents.
- ZERO_REG = 1:
  - Reads of address 0 return 0.
  - Writes to address 0 are discarded silently (no wr_drop).
- Multiple read ports on the same address return identical data.
- rst reasserted mid-CLEAR: the clear restarts from 0, giving a full DEPTH-cycle clear again.
- rst asserted during a write: the write is discarded.
- clr_cnt is ADDR_W bits; its wrap at DEPTH-1 coincides with the transition to READY.
- No X may propagate to rd_data after the first clear completes.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - In READY, if wr_en = 1 and rd_addr[i] == wr_addr, rd_data[i] = wr_data in the same cycle (write-through forwarding).
  - Excluded: address 0 when ZERO_REG = 1, and any cycle with busy high.
- Undefined:
  - No forwarding; rd_data[i] shows the old entry until the edge after the write.

Decomposition:
- Package regfile_pkg:
  - State enum {CLEAR, READY}.
  - Default DATA_W/ADDR_W constants shared with the CPU top.
  - Helper function for packed-port slicing.
- Sub-module regfile_clear_seq:
  - Owns the FSM, clr_cnt, busy and wr_drop.
  - Emits clr_we/clr_addr to the array.
  - The array and read muxes stay in regfile_param.

Test Plan:
- rst high for 2 cycles, then low: busy high for exactly 16 cycles (defaults); afterwards all 16 entries read 0x0000 on both ports.
- READY: write 0xBEEF to r5 → both ports at r5 read 0xBEEF next cycle; r6 still reads 0x0000.
- wr_en = 1 to r3 with data 0x1234 in cycle 4 of CLEAR → wr_drop pulses once; after clear, r3 reads 0x0000.
- ZERO_REG = 1: write 0xFFFF to r0 → r0 reads 0x0000; wr_drop stays 0.
- REGFILE_BYPASS_EN defined: write 0x00A5 to r7 while rd_addr[0] = 7 → rd_data[0] = 0x00A5 in the same cycle; undefined → old value, then 0x00A5 next cycle.
- rst pulsed at clear cycle 10 → busy remains high a further 16 cycles after rst falls; r15 previously 0x5555 reads 0x0000 at the end.
